sprite_motion_sched: RTL

- Frame-synchronous scheduler that owns position/direction state for NSPR bouncing sprites.
- Sweeps all sprite entries once per frame through one shared update datapath, one incrementer/decrementer plus bound compare.
- Sits between vga_sync (VSync) and the sprite renderers, which read committed positions through a registered read port.
- Host-side config port loads positions and directions.

---
 rtl/sprite_motion_sched.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sprite_motion_sched.sv
// Frame-synchronous motion scheduler for NSPR bouncing sprites: one shared
// LOAD/CALC/STORE datapath sweeps every entry once per VSync rising edge.
module sprite_motion_sched #(
  parameter int NSPR     = 4,
  parameter int IDXW     = 2,
  parameter int H_ACT    = 640,
  parameter int V_ACT    = 480,
  parameter int SPR_SIZE = 32
) (
  input  logic            CLK,
  input  logic            nReset,
  input  logic            VSync,
  input  logic            en,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_idx,
  input  logic [9:0]      cfg_x,
  input  logic [9:0]      cfg_y,
  input  logic            cfg_xd,
  input  logic            cfg_yd,
  output logic            cfg_err,
  input  logic [IDXW-1:0] rd_idx,
  output logic [9:0]      rd_x,
  output logic [9:0]      rd_y,
  output logic            busy,
  output logic            frame_done,
  output logic            ovr,
  output logic [15:0]     frame_cnt
);

  localparam logic [9:0]      X_HI     = 10'(H_ACT - 1 - SPR_SIZE);
  localparam logic [9:0]      Y_HI     = 10'(V_ACT - 1 - SPR_SIZE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSPR - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CALC  = 2'd2,
    STORE = 2'd3
  } state_t;

  // One axis step: returns {new_dir, new_pos}; the bound test uses the old position.
  function automatic logic [10:0] step_axis(input logic [9:0] pos,
                                            input logic       dir,
                                            input logic [9:0] hi);
    logic [9:0] npos;
    logic       ndir;
    if (dir) begin
      npos = pos + 10'd1;
      ndir = (pos >= hi) ? 1'b0 : 1'b1;
    end else begin
      npos = pos - 10'd1;
      ndir = (pos <= 10'd1) ? 1'b1 : 1'b0;
    end
    return {ndir, npos};
  endfunction

  state_t          state_r;
  logic [IDXW-1:0] idx_r;
  logic [9:0]      wx_r;
  logic [9:0]      wy_r;
  logic            wxd_r;
  logic            wyd_r;
  logic            vsync_q_r;

  logic [9:0]      ent_x_r  [NSPR];
  logic [9:0]      ent_y_r  [NSPR];
  logic            ent_xd_r [NSPR];
  logic            ent_yd_r [NSPR];

  logic            upd_s;
  logic            start_s;
  logic            cfg_ok_s;
  logic [9:0]      nx_s;
  logic [9:0]      ny_s;
  logic            ndx_s;
  logic            ndy_s;

  assign upd_s    = VSync & ~vsync_q_r;
  assign start_s  = upd_s & en & (state_r == IDLE);
  assign cfg_ok_s = cfg_we & (state_r == IDLE);

  // Next position/direction of the working entry for both axes.
  always_comb begin
    {ndx_s, nx_s} = step_axis(wx_r, wxd_r, X_HI);
    {ndy_s, ny_s} = step_axis(wy_r, wyd_r, Y_HI);
  end

  // Sprite entry table: host config writes in IDLE, sweep commits in STORE.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NSPR; i++) begin
        ent_x_r[i]  <= 10'(32 * (i + 1));
        ent_y_r[i]  <= 10'(32 * (i + 1));
        ent_xd_r[i] <= 1'b1;
        ent_yd_r[i] <= ((i % 2) == 1);
      end
    end else if (cfg_ok_s) begin
      ent_x_r[cfg_idx]  <= cfg_x;
      ent_y_r[cfg_idx]  <= cfg_y;
      ent_xd_r[cfg_idx] <= cfg_xd;
      ent_yd_r[cfg_idx] <= cfg_yd;
    end else if (state_r == STORE) begin
      ent_x_r[idx_r]  <= wx_r;
      ent_y_r[idx_r]  <= wy_r;
      ent_xd_r[idx_r] <= wxd_r;
      ent_yd_r[idx_r] <= wyd_r;
    end
  end

  // Sweep FSM with its status outputs and frame-edge detector.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      wx_r       <= 10'd0;
      wy_r       <= 10'd0;
      wxd_r      <= 1'b0;
      wyd_r      <= 1'b0;
      vsync_q_r  <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
      ovr        <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      vsync_q_r  <= VSync;
      frame_done <= 1'b0;
      cfg_err    <= cfg_we & busy;
      if (upd_s && busy) begin
        ovr <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r <= LOAD;
            idx_r   <= '0;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          wx_r    <= ent_x_r[idx_r];
          wy_r    <= ent_y_r[idx_r];
          wxd_r   <= ent_xd_r[idx_r];
          wyd_r   <= ent_yd_r[idx_r];
          state_r <= CALC;
        end
        CALC: begin
          wx_r    <= nx_s;
          wy_r    <= ny_s;
          wxd_r   <= ndx_s;
          wyd_r   <= ndy_s;
          state_r <= STORE;
        end
        STORE: begin
          if (idx_r == LAST_IDX) begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
          end else begin
            idx_r   <= idx_r + 1'b1;
            state_r <= LOAD;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Registered renderer read port over committed entries.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      rd_x <= 10'd0;
      rd_y <= 10'd0;
    end else begin
      rd_x <= ent_x_r[rd_idx];
      rd_y <= ent_y_r[rd_idx];
    end
  end

endmodule
